// File: rtl/deadlock_report_arbiter.sv
// Collects per-unit deadlock flags, elects the lowest-index origin and confirms
// persistence before declaring deadlock. A false alarm pulses token_clear instead.
module deadlock_report_arbiter #(
  parameter int PROC_NUM       = 3,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CLEAR_CYCLES   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                report_vld,
  output logic [4:0]          report_proc,
  output logic [7:0]          false_alarm_cnt
);

  localparam int MAXC = (CONFIRM_CYCLES > CLEAR_CYCLES) ? CONFIRM_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_CLEAR,
    S_DETECTED
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [PROC_NUM-1:0] r_origin, w_origin_nxt;
  logic [4:0]          r_idx, w_idx_nxt;
  logic                r_detect, w_detect_nxt;
  logic                r_tclr, w_tclr_nxt;
  logic                r_rvld, w_rvld_nxt;
  logic [4:0]          r_rproc, w_rproc_nxt;
  logic [7:0]          r_fa, w_fa_nxt;

  logic [PROC_NUM-1:0] w_low_onehot;
  logic [4:0]          w_low_idx;
  logic                w_found;
  logic                w_origin_hit;

  // Lowest-index set flag wins the election.
  always_comb begin
    w_low_onehot = '0;
    w_low_idx    = '0;
    w_found      = 1'b0;
    for (int unsigned i = 0; i < PROC_NUM; i++) begin
      if (dl_in_vec[i] && !w_found) begin
        w_found         = 1'b1;
        w_low_onehot[i] = 1'b1;
        w_low_idx       = 5'(i);
      end
    end
  end

  assign w_origin_hit = |(dl_in_vec & r_origin);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_origin_nxt = r_origin;
    w_idx_nxt    = r_idx;
    w_detect_nxt = r_detect;
    w_tclr_nxt   = 1'b0;
    w_rvld_nxt   = 1'b0;
    w_rproc_nxt  = r_rproc;
    w_fa_nxt     = r_fa;
    case (r_state)
      S_IDLE: begin
        w_origin_nxt = '0;
        if (w_found) begin
          w_state_nxt  = S_CONFIRM;
          w_cnt_nxt    = '0;
          w_origin_nxt = w_low_onehot;
          w_idx_nxt    = w_low_idx;
        end
      end
      S_CONFIRM: begin
        if (w_origin_hit) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CW'(CONFIRM_CYCLES - 1)) begin
            w_state_nxt  = S_DETECTED;
            w_detect_nxt = 1'b1;
            w_rvld_nxt   = 1'b1;
            w_rproc_nxt  = r_idx;
          end
        end else begin
          w_state_nxt  = S_CLEAR;
          w_cnt_nxt    = '0;
          w_origin_nxt = '0;
          w_tclr_nxt   = 1'b1;
          if (r_fa != 8'hFF) w_fa_nxt = r_fa + 8'd1;
        end
      end
      S_CLEAR: begin
        // token_clear is registered, so it is driven for the cycle that follows.
        if (r_cnt == CW'(CLEAR_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt  = r_cnt + 1'b1;
          w_tclr_nxt = 1'b1;
        end
      end
      S_DETECTED: begin
        w_state_nxt = S_DETECTED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_origin <= '0;
      r_idx    <= '0;
      r_detect <= 1'b0;
      r_tclr   <= 1'b0;
      r_rvld   <= 1'b0;
      r_rproc  <= '0;
      r_fa     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_origin <= w_origin_nxt;
      r_idx    <= w_idx_nxt;
      r_detect <= w_detect_nxt;
      r_tclr   <= w_tclr_nxt;
      r_rvld   <= w_rvld_nxt;
      r_rproc  <= w_rproc_nxt;
      r_fa     <= w_fa_nxt;
    end
  end

  assign dl_detect_out   = r_detect;
  assign origin          = r_origin;
  assign token_clear     = r_tclr;
  assign report_vld      = r_rvld;
  assign report_proc     = r_rproc;
  assign false_alarm_cnt = r_fa;

endmodule

// File: tb/tb_deadlock_report_arbiter.sv
// Directed bench for deadlock_report_arbiter (3 units, 4 confirm, 2 clear cycles)
// plus a second instance with a single confirm cycle.
module tb_deadlock_report_arbiter;

  logic       clock;
  logic       reset;
  logic [2:0] dl_in_vec;

  logic       dl_detect_out, token_clear, report_vld;
  logic [2:0] origin;
  logic [4:0] report_proc;
  logic [7:0] false_alarm_cnt;

  logic       dl_detect_out1, token_clear1, report_vld1;
  logic [2:0] origin1;
  logic [4:0] report_proc1;
  logic [7:0] false_alarm_cnt1;

  int errors;
  int checks;

  deadlock_report_arbiter #(
    .PROC_NUM      (3),
    .CONFIRM_CYCLES(4),
    .CLEAR_CYCLES  (2)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .dl_in_vec      (dl_in_vec),
    .dl_detect_out  (dl_detect_out),
    .origin         (origin),
    .token_clear    (token_clear),
    .report_vld     (report_vld),
    .report_proc    (report_proc),
    .false_alarm_cnt(false_alarm_cnt)
  );

  deadlock_report_arbiter #(
    .PROC_NUM      (3),
    .CONFIRM_CYCLES(1),
    .CLEAR_CYCLES  (2)
  ) u_dut1 (
    .clock          (clock),
    .reset          (reset),
    .dl_in_vec      (dl_in_vec),
    .dl_detect_out  (dl_detect_out1),
    .origin         (origin1),
    .token_clear    (token_clear1),
    .report_vld     (report_vld1),
    .report_proc    (report_proc1),
    .false_alarm_cnt(false_alarm_cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".detect"}, 32'(dl_detect_out), 32'h0);
    chk({tag, ".origin"}, 32'(origin), 32'h0);
    chk({tag, ".tclr"}, 32'(token_clear), 32'h0);
    chk({tag, ".rvld"}, 32'(report_vld), 32'h0);
    chk({tag, ".rproc"}, 32'(report_proc), 32'h0);
    chk({tag, ".fa"}, 32'(false_alarm_cnt), 32'h0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    dl_in_vec = 3'b000;
    repeat (3) tick();
    chk_all_zero("rst");
    reset = 1'b1;

    // 1: idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle.detect", 32'(dl_detect_out), 32'h0);
    end
    chk_all_zero("idle");

    // 2: 110 held -> origin 010, detect four cycles later
    dl_in_vec = 3'b110;
    tick();
    chk("t2.origin", 32'(origin), 32'h2);
    chk("t2.detect_c1", 32'(dl_detect_out), 32'h0);
    chk("t2.cc1_detect", 32'(dl_detect_out1), 32'h0);
    chk("t2.cc1_origin", 32'(origin1), 32'h2);
    tick();
    chk("t2.cc1_detect2", 32'(dl_detect_out1), 32'h1);
    chk("t2.cc1_rvld", 32'(report_vld1), 32'h1);
    chk("t2.cc1_rproc", 32'(report_proc1), 32'h1);
    chk("t2.detect_c2", 32'(dl_detect_out), 32'h0);
    tick();
    chk("t2.detect_c3", 32'(dl_detect_out), 32'h0);
    tick();
    chk("t2.detect_c4", 32'(dl_detect_out), 32'h0);
    chk("t2.rvld_c4", 32'(report_vld), 32'h0);
    tick();
    chk("t2.detect", 32'(dl_detect_out), 32'h1);
    chk("t2.rvld", 32'(report_vld), 32'h1);
    chk("t2.rproc", 32'(report_proc), 32'h1);
    dl_in_vec = 3'b001;
    tick();
    chk("t2.rvld_off", 32'(report_vld), 32'h0);
    chk("t2.detect_hold", 32'(dl_detect_out), 32'h1);
    repeat (3) tick();
    chk("t2.origin_hold", 32'(origin), 32'h2);
    chk("t2.rproc_hold", 32'(report_proc), 32'h1);
    chk("t2.detect_sticky", 32'(dl_detect_out), 32'h1);

    // 6a: asynchronous reset while DETECTED
    #3 reset = 1'b0;
    #1;
    chk_all_zero("rst_det");
    dl_in_vec = 3'b000;
    tick();
    reset = 1'b1;
    tick();

    // 3: false alarm
    dl_in_vec = 3'b001;
    tick();
    chk("t3.origin_c11", 32'(origin), 32'h1);
    tick();
    chk("t3.origin_c12", 32'(origin), 32'h1);
    dl_in_vec = 3'b000;
    tick();
    chk("t3.tclr_c13", 32'(token_clear), 32'h1);
    chk("t3.origin_c13", 32'(origin), 32'h0);
    chk("t3.fa", 32'(false_alarm_cnt), 32'h1);
    dl_in_vec = 3'b111;
    tick();
    chk("t3.tclr_c14", 32'(token_clear), 32'h1);
    chk("t3.origin_c14", 32'(origin), 32'h0);
    tick();
    chk("t3.tclr_c15", 32'(token_clear), 32'h0);
    chk("t3.origin_c15", 32'(origin), 32'h0);
    dl_in_vec = 3'b000;
    tick();
    chk("t3.origin_c16", 32'(origin), 32'h0);
    chk("t3.fa_hold", 32'(false_alarm_cnt), 32'h1);

    // 4: other bits ignored during CONFIRM
    dl_in_vec = 3'b001;
    tick();
    chk("t4.origin", 32'(origin), 32'h1);
    dl_in_vec = 3'b101;
    repeat (3) tick();
    chk("t4.origin_hold", 32'(origin), 32'h1);
    chk("t4.detect_early", 32'(dl_detect_out), 32'h0);
    tick();
    chk("t4.detect", 32'(dl_detect_out), 32'h1);
    chk("t4.rvld", 32'(report_vld), 32'h1);
    chk("t4.rproc", 32'(report_proc), 32'h0);
    chk("t4.fa", 32'(false_alarm_cnt), 32'h1);

    // 6b: asynchronous reset while CLEAR, then restart
    reset = 1'b0;
    dl_in_vec = 3'b000;
    tick();
    reset = 1'b1;
    dl_in_vec = 3'b010;
    tick();
    dl_in_vec = 3'b000;
    tick();
    chk("t6.tclr_pre", 32'(token_clear), 32'h1);
    #3 reset = 1'b0;
    #1;
    chk("t6.tclr_rst", 32'(token_clear), 32'h0);
    chk("t6.fa_rst", 32'(false_alarm_cnt), 32'h0);
    tick();
    reset = 1'b1;
    dl_in_vec = 3'b100;
    tick();
    chk("t6.origin", 32'(origin), 32'h4);
    chk("t6.tclr", 32'(token_clear), 32'h0);
    dl_in_vec = 3'b000;
    repeat (3) tick();

    // 5: 260 false alarms saturate at 255
    chk("t5.fa_start", 32'(false_alarm_cnt), 32'h1);
    for (int i = 1; i < 260; i++) begin
      dl_in_vec = 3'b001;
      tick();
      dl_in_vec = 3'b000;
      repeat (3) tick();
      chk("t5.fa", 32'(false_alarm_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    chk("t5.detect", 32'(dl_detect_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deadlock_report_arbiter.md
Name: deadlock_report_arbiter

Overview:
Central collector for the per-process deadlock detect units of one dataflow region. Accepts each unit's dl_detect flag, elects a single origin process, and confirms that the flag persists before declaring deadlock. On a false alarm it broadcasts token_clear so the dependency-token ring restarts; on a confirmed deadlock it freezes the detect units via dl_detect_out and emits a one-shot report.

Parameters:
PROC_NUM, 3, number of dataflow processes / detect units (1..32)
CONFIRM_CYCLES, 16, consecutive cycles the origin's flag must hold before deadlock is declared (>=1)
CLEAR_CYCLES, 2, length of the token_clear pulse after a false alarm (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
dl_in_vec  in  PROC_NUM  per-unit deadlock flag from each detect unit
dl_detect_out  out  1  confirmed deadlock; freezes the detect units' dependency vectors
origin  out  PROC_NUM  one-hot elected origin unit; all-zero when none is elected
token_clear  out  1  clear all dependency tokens in the ring
report_vld  out  1  single-cycle pulse on deadlock confirmation
report_proc  out  5  binary index of the origin, valid while report_vld=1 and held afterwards
false_alarm_cnt  out  8  saturating count of aborted confirmations

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs to 0, the state to IDLE and the counters to 0. Reset asserted mid-operation aborts any state immediately, including DETECTED.
- All outputs are registered. The FSM has four states: IDLE, CONFIRM, CLEAR, DETECTED.
- IDLE: origin=0, token_clear=0. If dl_in_vec!=0 in cycle N, the lowest-index set bit is latched into origin, visible in cycle N+1. The state becomes CONFIRM and cnt=0. If several bits are set simultaneously, only the lowest index wins.
- CONFIRM: origin is held and other dl_in_vec bits are ignored. Each cycle:
  - If dl_in_vec[origin]=1, cnt increments.
  - If the bit is 1 and cnt==CONFIRM_CYCLES-1, the next state is DETECTED.
  - If the bit is 0, the next state is CLEAR and false_alarm_cnt increments (saturating at 255).
- Timing: with origin first visible in cycle N+1 and the bit held through cycles N+1..N+CONFIRM_CYCLES, dl_detect_out=1 and report_vld=1 in cycle N+CONFIRM_CYCLES+1.
- CLEAR: origin=0 and token_clear=1 for exactly CLEAR_CYCLES cycles. dl_in_vec is ignored throughout. The state then returns to IDLE, and new flags are sampled starting from the first IDLE cycle.
- DETECTED: the state is terminal until reset.
  - dl_detect_out=1 and origin held (sticky).
  - report_vld=1 only in the first cycle.
  - report_proc = index of the origin, latched at entry.
  - dl_in_vec is ignored.
- Edge cases:
  - CONFIRM_CYCLES=1: DETECTED is entered after a single held cycle of CONFIRM.
  - report_proc width is fixed at 5; upper bits are zero.

Test Plan (PROC_NUM=3, CONFIRM_CYCLES=4, CLEAR_CYCLES=2):
1. Reset released, dl_in_vec=000 for 20 cycles -> all outputs 0, false_alarm_cnt=0.
2. dl_in_vec=110 from cycle 10 and held -> origin=010 at cycle 11; dl_detect_out=1 and report_vld=1 at cycle 15, with report_proc=1; report_vld=0 at cycle 16 while dl_detect_out stays 1.
3. dl_in_vec=001 in cycle 10, dropped to 000 at cycle 12 -> origin=001 during cycles 11-12; token_clear=1 and origin=000 in cycles 13-14; false_alarm_cnt=1; IDLE from cycle 15.
4. In CONFIRM with origin=001, dl_in_vec changes to 101 -> origin stays 001 and confirmation completes normally.
5. 260 consecutive false alarms -> false_alarm_cnt saturates at 255.
6. reset pulsed low while in DETECTED (also while in CLEAR) -> outputs zero asynchronously; after release, a new flag restarts confirmation from IDLE.
